// File: rtl/bottle_pkg.sv
// Shared FSM encoding, BCD digit width, default targets and BCD<->binary helpers.
// Helpers operate on up to four BCD digits; callers cast to their own width.
package bottle_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;
    localparam int BIN_W      = 14;

    localparam logic [15:0] DEF_PILLS = 16'h0010;
    localparam logic [15:0] DEF_BOTS  = 16'h0010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SET  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_FULL = 3'd4
    } state_t;

    function automatic logic [BIN_W-1:0] bcd2bin(input logic [15:0] b);
        logic [BIN_W-1:0] acc;
        acc = '0;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            acc = acc * 14'd10 + BIN_W'(b[BCD_W*k +: BCD_W]);
        end
        return acc;
    endfunction

    function automatic logic [15:0] bin2bcd(input logic [BIN_W-1:0] v);
        logic [15:0]      r;
        logic [BIN_W-1:0] t;
        r = '0;
        t = v;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            r[BCD_W*k +: BCD_W] = 4'(t % 14'd10);
            t = t / 14'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with clear > load > increment priority; q updates one cycle later.
// term flags that the value about to be written (load value, else q+1) equals tgt.
module bcd_counter
    import bottle_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      inc,
    input  logic                      ld,
    input  logic [BCD_W*DIGITS-1:0]   ld_val,
    input  logic [BCD_W*DIGITS-1:0]   tgt,
    output logic [BCD_W*DIGITS-1:0]   q,
    output logic                      term
);

    logic [BCD_W*DIGITS-1:0] q_inc;
    logic [BCD_W*DIGITS-1:0] q_nxt;
    logic                    carry;

    always_comb begin
        q_inc = q;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (q[BCD_W*k +: BCD_W] == 4'd9) begin
                    q_inc[BCD_W*k +: BCD_W] = 4'd0;
                end else begin
                    q_inc[BCD_W*k +: BCD_W] = q[BCD_W*k +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        q_nxt = ld ? ld_val : q_inc;
        term  = (q_nxt == tgt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (inc) begin
            q <= q_inc;
        end
    end

endmodule

// File: rtl/bottle_fill_ctrl.sv
// Multi-lane pill/bottle filling controller with BCD targets, hold/resume and full detection.
// All outputs are registered state; pill and strobe effects are visible one cycle later.
module bottle_fill_ctrl
    import bottle_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int LANES  = 4
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            EN_set,
    input  logic                            EN_work,
    input  logic                            SET,
    input  logic [BCD_W*DIGITS-1:0]         set_val,
    input  logic                            set_stb,
    input  logic [LANES-1:0]                pill,
    input  logic                            conti,
    input  logic                            resume,
    output logic [BCD_W*DIGITS*LANES-1:0]   lane_cnt,
    output logic [BCD_W*DIGITS-1:0]         bot_cnt,
    output logic [LANES-1:0]                lane_hold,
    output logic [2:0]                      state,
    output logic                            all_full,
    output logic                            cfg_err
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [W-1:0] PILL_DEF = (DIGITS == 1) ? W'(4'h9) : W'(DEF_PILLS);
    localparam logic [W-1:0] BOT_DEF  = (DIGITS == 1) ? W'(4'h9) : W'(DEF_BOTS);

    state_t           st, nxt_st;
    logic [W-1:0]     pills_tgt, bots_tgt;
    logic             clear_all, run, val_ok;
    logic [LANES-1:0] pill_ok, lane_term, done, hold_nxt;
    logic             bot_ld, bot_hit;
    logic [W-1:0]     bot_ld_val;
    logic [BIN_W-1:0] bot_sum, bot_max;

    assign pill_ok  = {LANES{run}} & pill & ~lane_hold;
    assign done     = pill_ok & lane_term;
    assign hold_nxt = lane_hold | (done & ~{LANES{conti}});

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bcd_counter #(.DIGITS(DIGITS)) u_lane (
            .clk    (CLK),
            .rst_n  (RST_N),
            .clr    (clear_all | done[i]),
            .inc    (pill_ok[i]),
            .ld     (1'b0),
            .ld_val ('0),
            .tgt    (pills_tgt),
            .q      (lane_cnt[i*W +: W]),
            .term   (lane_term[i])
        );
    end

    // Several lanes may finish together: add the popcount in binary, clamp, convert back.
    always_comb begin
        bot_sum = bcd2bin(16'(bot_cnt));
        for (int i = 0; i < LANES; i++) begin
            bot_sum = bot_sum + BIN_W'(done[i]);
        end
        bot_max = bcd2bin(16'(bots_tgt));
        if (bot_sum > bot_max) begin
            bot_sum = bot_max;
        end
        bot_ld_val = W'(bin2bcd(bot_sum));
        bot_ld     = |done;
    end

    bcd_counter #(.DIGITS(DIGITS)) u_bot (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clr    (clear_all),
        .inc    (1'b0),
        .ld     (bot_ld),
        .ld_val (bot_ld_val),
        .tgt    (bots_tgt),
        .q      (bot_cnt),
        .term   (bot_hit)
    );

    always_comb begin
        val_ok = (set_val != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (set_val[BCD_W*k +: BCD_W] > 4'd9) begin
                val_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pills_tgt <= PILL_DEF;
            bots_tgt  <= BOT_DEF;
            cfg_err   <= 1'b0;
            lane_hold <= '0;
        end else begin
            if (st == ST_SET && set_stb) begin
                cfg_err <= !val_ok;
                if (val_ok) begin
                    if (SET) bots_tgt  <= set_val;
                    else     pills_tgt <= set_val;
                end
            end
            if (clear_all || (st == ST_HOLD && resume)) begin
                lane_hold <= '0;
            end else begin
                lane_hold <= hold_nxt;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st <= ST_IDLE;
        end else begin
            st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = st;
        if (EN_set) begin
            nxt_st = ST_SET;
        end else begin
            case (st)
                ST_IDLE: if (EN_work && pills_tgt != '0 && bots_tgt != '0) nxt_st = ST_RUN;
                ST_SET:  nxt_st = ST_IDLE;
                ST_RUN: begin
                    if (bot_ld && bot_hit)  nxt_st = ST_FULL;
                    else if (!EN_work)      nxt_st = ST_IDLE;
                    else if (&hold_nxt)     nxt_st = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!EN_work)    nxt_st = ST_IDLE;
                    else if (resume) nxt_st = ST_RUN;
                end
                ST_FULL: nxt_st = ST_FULL;
                default: nxt_st = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        state     = st;
        all_full  = (st == ST_FULL);
        run       = (st == ST_RUN);
        clear_all = EN_set && (st != ST_SET);
    end

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Table-driven bench for bottle_fill_ctrl (DIGITS=2, LANES=4) with an expected-result queue.
module tb_bottle_fill_ctrl;
    import bottle_pkg::*;

    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        EN_set = 1'b0, EN_work = 1'b0, SET = 1'b0, set_stb = 1'b0;
    logic [7:0]  set_val = 8'h00;
    logic [3:0]  pill = 4'h0;
    logic        conti = 1'b0, resume = 1'b0;
    logic [31:0] lane_cnt;
    logic [7:0]  bot_cnt;
    logic [3:0]  lane_hold;
    logic [2:0]  state;
    logic        all_full, cfg_err;

    always #5 CLK = ~CLK;

    bottle_fill_ctrl #(.DIGITS(2), .LANES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN_set(EN_set), .EN_work(EN_work), .SET(SET),
        .set_val(set_val), .set_stb(set_stb), .pill(pill), .conti(conti), .resume(resume),
        .lane_cnt(lane_cnt), .bot_cnt(bot_cnt), .lane_hold(lane_hold), .state(state),
        .all_full(all_full), .cfg_err(cfg_err)
    );

    typedef struct {
        logic        set, work, sel;
        logic [7:0]  val;
        logic        stb;
        logic [3:0]  pill;
        logic        conti, resume;
        logic [2:0]  st;
        logic [7:0]  bot;
        logic [31:0] lanes;
        logic [3:0]  hold;
        logic        full, err;
    } vec_t;

    localparam int NA = 11;
    localparam int NT = 17;

    vec_t tbl[NT];
    vec_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t v(input logic set_i, work_i, sel_i, input logic [7:0] val_i,
                               input logic stb_i, input logic [3:0] pill_i,
                               input logic conti_i, resume_i, input logic [2:0] st_i,
                               input logic [7:0] bot_i, input logic [31:0] lanes_i,
                               input logic [3:0] hold_i, input logic full_i, err_i);
        vec_t r;
        r.set = set_i;   r.work = work_i; r.sel = sel_i;     r.val = val_i;
        r.stb = stb_i;   r.pill = pill_i; r.conti = conti_i; r.resume = resume_i;
        r.st = st_i;     r.bot = bot_i;   r.lanes = lanes_i; r.hold = hold_i;
        r.full = full_i; r.err = err_i;
        return r;
    endfunction

    function automatic logic [7:0] bcd2(input int p);
        return 8'(((p / 10) * 16) + (p % 10));
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s/%s: got %h required %h", tag, name, act, req);
        end
    endtask

    task automatic step(input string tag, input vec_t tv);
        vec_t e;
        EN_set = tv.set;   EN_work = tv.work; SET = tv.sel;     set_val = tv.val;
        set_stb = tv.stb;  pill = tv.pill;    conti = tv.conti; resume = tv.resume;
        exp_q.push_back(tv);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk(tag, "state",     32'(state),     32'(e.st));
        chk(tag, "bot_cnt",   32'(bot_cnt),   32'(e.bot));
        chk(tag, "lane_cnt",  lane_cnt,       e.lanes);
        chk(tag, "lane_hold", 32'(lane_hold), 32'(e.hold));
        chk(tag, "all_full",  32'(all_full),  32'(e.full));
        chk(tag, "cfg_err",   32'(cfg_err),   32'(e.err));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, "state",     32'(state),     32'(ST_IDLE));
        chk(tag, "lane_cnt",  lane_cnt,       32'h0);
        chk(tag, "bot_cnt",   32'(bot_cnt),   32'h0);
        chk(tag, "lane_hold", 32'(lane_hold), 32'h0);
        chk(tag, "all_full",  32'(all_full),  32'h0);
        chk(tag, "cfg_err",   32'(cfg_err),   32'h0);
    endtask

    initial begin
        // config writes, bad-digit and zero rejects, pause and pill gating
        tbl[0]  = v(1,0,0,8'h00,0,4'h0,0,0, ST_SET,  8'h00, 32'h0,  4'h0,0,0);
        tbl[1]  = v(1,0,0,8'h1A,1,4'h0,0,0, ST_SET,  8'h00, 32'h0,  4'h0,0,1);
        tbl[2]  = v(1,0,0,8'h00,1,4'h0,0,0, ST_SET,  8'h00, 32'h0,  4'h0,0,1);
        tbl[3]  = v(1,0,0,8'h12,1,4'h0,0,0, ST_SET,  8'h00, 32'h0,  4'h0,0,0);
        tbl[4]  = v(0,0,0,8'h00,0,4'h0,0,0, ST_IDLE, 8'h00, 32'h0,  4'h0,0,0);
        tbl[5]  = v(0,1,0,8'h00,0,4'h0,1,0, ST_RUN,  8'h00, 32'h0,  4'h0,0,0);
        tbl[6]  = v(0,1,0,8'h00,0,4'h1,1,0, ST_RUN,  8'h00, 32'h01, 4'h0,0,0);
        tbl[7]  = v(0,1,0,8'h00,0,4'h1,1,0, ST_RUN,  8'h00, 32'h02, 4'h0,0,0);
        tbl[8]  = v(0,0,0,8'h00,0,4'h0,1,0, ST_IDLE, 8'h00, 32'h02, 4'h0,0,0);
        tbl[9]  = v(0,0,0,8'h00,0,4'h1,1,0, ST_IDLE, 8'h00, 32'h02, 4'h0,0,0);
        tbl[10] = v(0,1,0,8'h00,0,4'h0,1,0, ST_RUN,  8'h00, 32'h02, 4'h0,0,0);
        // SET priority over EN_work, clears counts; pills 03, bottles 02
        tbl[11] = v(1,1,0,8'h00,0,4'h0,1,0, ST_SET,  8'h00, 32'h0,  4'h0,0,0);
        tbl[12] = v(1,0,1,8'hA0,1,4'h0,1,0, ST_SET,  8'h00, 32'h0,  4'h0,0,1);
        tbl[13] = v(1,0,1,8'h02,1,4'h0,1,0, ST_SET,  8'h00, 32'h0,  4'h0,0,0);
        tbl[14] = v(1,0,0,8'h03,1,4'h0,1,0, ST_SET,  8'h00, 32'h0,  4'h0,0,0);
        tbl[15] = v(0,0,0,8'h00,0,4'h0,1,0, ST_IDLE, 8'h00, 32'h0,  4'h0,0,0);
        tbl[16] = v(0,1,0,8'h00,0,4'h0,1,0, ST_RUN,  8'h00, 32'h0,  4'h0,0,0);

        #12;
        check_idle_outputs("reset");
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < NA; i++) step($sformatf("tbl%0d", i), tbl[i]);
        // pills target 12 accepted: 12th pill completes a bottle
        for (int p = 3; p <= 12; p++)
            step("tgt12", v(0,1,0,8'h00,0,4'h1,1,0, ST_RUN, (p == 12) ? 8'h01 : 8'h00,
                            (p == 12) ? 32'h0 : 32'(bcd2(p)), 4'h0, 0, 0));
        for (int i = NA; i < NT; i++) step($sformatf("tbl%0d", i), tbl[i]);

        for (int p = 1; p <= 6; p++)
            step("single", v(0,1,0,8'h00,0,4'h1,1,0, (p == 6) ? ST_FULL : ST_RUN,
                             8'(p / 3), 32'(p % 3), 4'h0, (p == 6), 0));
        step("full_pill", v(0,1,0,8'h00,0,4'hF,1,0, ST_FULL, 8'h02, 32'h0, 4'h0,1,0));
        step("full_stay", v(0,0,0,8'h00,0,4'h0,1,0, ST_FULL, 8'h02, 32'h0, 4'h0,1,0));

        step("sim_set",  v(1,0,0,8'h00,0,4'h0,1,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("sim_wp",   v(1,0,0,8'h01,1,4'h0,1,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("sim_wb",   v(1,0,1,8'h03,1,4'h0,1,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("sim_idle", v(0,0,0,8'h00,0,4'h0,1,0, ST_IDLE, 8'h00, 32'h0, 4'h0,0,0));
        step("sim_run",  v(0,1,0,8'h00,0,4'h0,1,0, ST_RUN,  8'h00, 32'h0, 4'h0,0,0));
        step("sim_all",  v(0,1,0,8'h00,0,4'hF,1,0, ST_FULL, 8'h03, 32'h0, 4'h0,1,0));

        step("hold_set", v(1,0,0,8'h00,0,4'h0,0,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("hold_wp",  v(1,0,0,8'h02,1,4'h0,0,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("hold_wb",  v(1,0,1,8'h99,1,4'h0,0,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("hold_idl", v(0,0,0,8'h00,0,4'h0,0,0, ST_IDLE, 8'h00, 32'h0, 4'h0,0,0));
        step("hold_run", v(0,1,0,8'h00,0,4'h0,0,0, ST_RUN,  8'h00, 32'h0, 4'h0,0,0));
        step("hold_a",   v(0,1,0,8'h00,0,4'h2,0,0, ST_RUN,  8'h00, 32'h0000_0100, 4'h0,0,0));
        step("hold_b",   v(0,1,0,8'h00,0,4'h2,0,0, ST_RUN,  8'h01, 32'h0, 4'h2,0,0));
        step("hold_c",   v(0,1,0,8'h00,0,4'h2,0,0, ST_RUN,  8'h01, 32'h0, 4'h2,0,0));
        step("hold_d",   v(0,1,0,8'h00,0,4'hD,0,0, ST_RUN,  8'h01, 32'h0101_0001, 4'h2,0,0));
        step("hold_e",   v(0,1,0,8'h00,0,4'hD,0,0, ST_HOLD, 8'h04, 32'h0, 4'hF,0,0));
        step("hold_f",   v(0,1,0,8'h00,0,4'hF,0,0, ST_HOLD, 8'h04, 32'h0, 4'hF,0,0));
        step("hold_res", v(0,1,0,8'h00,0,4'h0,0,1, ST_RUN,  8'h04, 32'h0, 4'h0,0,0));
        step("hold_h",   v(0,1,0,8'h00,0,4'h1,0,0, ST_RUN,  8'h04, 32'h01, 4'h0,0,0));

        step("car_set",  v(1,0,0,8'h00,0,4'h0,0,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("car_wp",   v(1,0,0,8'h15,1,4'h0,0,0, ST_SET,  8'h00, 32'h0, 4'h0,0,0));
        step("car_wbad", v(1,0,1,8'hF0,1,4'h0,0,0, ST_SET,  8'h00, 32'h0, 4'h0,0,1));
        step("car_idle", v(0,0,0,8'h00,0,4'h0,0,0, ST_IDLE, 8'h00, 32'h0, 4'h0,0,1));
        step("car_run",  v(0,1,0,8'h00,0,4'h0,0,0, ST_RUN,  8'h00, 32'h0, 4'h0,0,1));
        for (int p = 1; p <= 15; p++)
            step("carry", v(0,1,0,8'h00,0,4'h1,0,0, ST_RUN, (p == 15) ? 8'h01 : 8'h00,
                            (p == 15) ? 32'h0 : 32'(bcd2(p)), (p == 15) ? 4'h1 : 4'h0, 0, 1));
        for (int p = 1; p <= 5; p++)
            step("lane2", v(0,1,0,8'h00,0,4'h4,0,0, ST_RUN, 8'h01,
                            32'(bcd2(p)) << 16, 4'h1, 0, 1));

        EN_set = 1'b0; EN_work = 1'b0; SET = 1'b0; set_val = 8'h00; set_stb = 1'b0;
        pill = 4'h0; conti = 1'b0; resume = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        #10;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        step("def_run", v(0,1,0,8'h00,0,4'h0,1,0, ST_RUN, 8'h00, 32'h0, 4'h0,0,0));
        for (int p = 1; p <= 10; p++)
            step("def_tgt", v(0,1,0,8'h00,0,4'h1,1,0, ST_RUN, (p == 10) ? 8'h01 : 8'h00,
                              (p == 10) ? 32'h0 : 32'(bcd2(p)), 4'h0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
